// File: rtl/niosv_gpi_edge_capture_if.sv
// Avalon-MM slave bus bundle for the GPI edge-capture block.
// The master drives address/strobes/writedata; the slave returns registered readdata.
interface niosv_gpi_edge_capture_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niosv_gpi_edge_capture.sv
// General-purpose input port: per-pin synchroniser, debounce filter, edge detector,
// write-1-to-clear capture register and a level interrupt for unmasked captures.
module niosv_gpi_edge_capture #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  niosv_gpi_edge_capture_if.slave  bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;

  logic [WIDTH-1:0] sync1, s, d, d_prev;
  logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edgecapture;
  logic [WIDTH-1:0] rise, fall, clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic [31:0]      rdata, rd_next;
  logic             wr_strobe;
  logic             wdata_unused;

  assign wr_strobe    = bus.chipselect && !bus.write_n;
  assign wdata_unused = ^bus.writedata;
  assign bus.readdata = rdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= in_port;
      s     <= sync1;
    end
  end

  // NOTE: the counter array is ordinary flops, not a RAM, so it is reset element by element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == d[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          d[i]   <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = d & ~d_prev & rise_en;
  assign fall = ~d & d_prev & fall_en;
  assign clr  = (wr_strobe && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_prev      <= '0;
      rise_en     <= '0;
      fall_en     <= '0;
      irq_mask    <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
    end else begin
      d_prev <= d;
      if (wr_strobe && bus.address == ADDR_RISE) rise_en  <= bus.writedata[WIDTH-1:0];
      if (wr_strobe && bus.address == ADDR_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
      if (wr_strobe && bus.address == ADDR_FALL) fall_en  <= bus.writedata[WIDTH-1:0];
      // New edges are OR-ed after the clear so a same-cycle set wins.
      edgecapture <= (edgecapture & ~clr) | rise | fall;
      irq         <= |(edgecapture & irq_mask);
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA: rd_next[WIDTH-1:0] = d;
      ADDR_RISE: rd_next[WIDTH-1:0] = rise_en;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edgecapture;
      ADDR_FALL: rd_next[WIDTH-1:0] = fall_en;
      default:   rd_next = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect (readLatency = 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= rd_next;
  end

endmodule

// File: tb/tb_niosv_gpi_edge_capture.sv
// Scoreboard bench: a window-based debounce reference model predicts register reads and irq;
// a negedge monitor pops expected read data and compares irq every cycle.
module tb_niosv_gpi_edge_capture;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  logic         irq;
  bit           rd_req;

  int checks = 0;
  int errors = 0;

  niosv_gpi_edge_capture_if bus ();

  niosv_gpi_edge_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] d_m, dp_m, re_m, fe_m, mk_m, ec_m;
  logic         irq_m;
  logic [W-1:0] hist [$];   // in_port samples of the last D+1 edges, oldest first
  logic [31:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // The filtered bit follows a pin once its synchronised value has held one
  // value, different from the filtered one, for D consecutive sampled edges.
  function automatic logic [W-1:0] debounce_next();
    logic [W-1:0] nxt, h0, hi;
    nxt = d_m;
    h0  = hist[0];
    for (int b = 0; b < W; b++) begin
      bit stable = 1'b1;
      for (int i = 1; i < D; i++) begin
        hi = hist[i];
        if (hi[b] != h0[b]) stable = 1'b0;
      end
      if (stable && h0[b] != d_m[b]) nxt[b] = h0[b];
    end
    return nxt;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = d_m;
      3'd1: r[W-1:0] = re_m;
      3'd2: r[W-1:0] = mk_m;
      3'd3: r[W-1:0] = ec_m;
      3'd4: r[W-1:0] = fe_m;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      d_m <= '0; dp_m <= '0; re_m <= '0; fe_m <= '0; mk_m <= '0; ec_m <= '0;
      irq_m <= 1'b0;
      hist.delete();
      for (int i = 0; i <= D; i++) hist.push_back('0);
      exp_q.delete();
    end else begin
      logic wr;
      logic [W-1:0] clr_m;
      wr    = bus.chipselect && !bus.write_n;
      clr_m = (wr && bus.address == 3'd3) ? bus.writedata[W-1:0] : '0;
      if (rd_req) exp_q.push_back(model_read(bus.address));
      irq_m <= |(ec_m & mk_m);
      ec_m  <= (ec_m & ~clr_m) | (d_m & ~dp_m & re_m) | (~d_m & dp_m & fe_m);
      if (wr && bus.address == 3'd1) re_m <= bus.writedata[W-1:0];
      if (wr && bus.address == 3'd2) mk_m <= bus.writedata[W-1:0];
      if (wr && bus.address == 3'd4) fe_m <= bus.writedata[W-1:0];
      dp_m <= d_m;
      d_m  <= debounce_next();
      hist.push_back(in_port);
      void'(hist.pop_front());
    end
  end

  // Monitor: readdata is presented one edge after each issued read
  always @(negedge clk) begin
    if (!reset) begin
      check("irq", {31'd0, irq}, {31'd0, irq_m});
      if (exp_q.size() > 0) check("readdata", bus.readdata, exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    bus.address = a; bus.writedata = v; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    cyc();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    bus.address = a; rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; in_port = '0; rd_req = 1'b0;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", bus.readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    // All addresses read 0 after reset; inputs high with no enables capture nothing
    for (int a = 0; a < 8; a++) rd(3'(a));
    in_port = 8'hFF;
    repeat (D + 4) rd(3'd0);
    rd(3'd3);
    check("no_capture_at_power_up", bus.readdata, 32'd0);

    // Rising-edge latency on bit 0 and write-1-to-clear
    in_port = 8'h00;
    repeat (D + 5) cyc();
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h01);
    in_port = 8'h01;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (irq) begin n = i; break; end
    end
    check("irq_latency_edges", n, D + 4);
    rd(3'd3);
    check("capture_bit0", bus.readdata, 32'h01);
    wr(3'd3, 32'h01);
    check("irq_hold_on_clear_edge", {31'd0, irq}, 32'd1);
    cyc();
    check("irq_low_after_clear", {31'd0, irq}, 32'd0);

    // Bounce on bit 2 then settle high: exactly one capture
    wr(3'd1, 32'h04);
    wr(3'd4, 32'h04);
    wr(3'd3, 32'hFF);
    for (int t = 0; t < 20; t++) begin
      in_port[2] = ~in_port[2];
      repeat (5) rd(3'd0);
    end
    in_port[2] = 1'b1;
    repeat (D + 3) rd(3'd0);
    repeat (3) cyc();
    rd(3'd3);
    check("bounce_single_capture", bus.readdata, 32'h04);

    // Rising event on bit 3 on the same edge as its clear: set wins
    wr(3'd1, 32'h08);
    wr(3'd3, 32'hFF);
    in_port[3] = 1'b1;
    repeat (D + 2) cyc();
    wr(3'd3, 32'h08);
    rd(3'd3);
    check("set_wins_over_clear", bus.readdata & 32'h08, 32'h08);

    // Masked capture, late unmask, read-only data register
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h20);
    wr(3'd3, 32'hFF);
    in_port[5] = 1'b1;
    repeat (D + 6) cyc();
    check("masked_irq_low", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'hFF);
    cyc();
    check("unmask_irq_high", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'h00);
    rd(3'd0);
    check("data_read_only", bus.readdata, {24'd0, in_port});

    // Reset in the middle of a debounce count
    wr(3'd1, 32'hFF);
    in_port = 8'h00;
    repeat (D + 5) cyc();
    in_port = 8'hFF;
    repeat (12) cyc();
    reset = 1'b1;
    cyc();
    check("midcount_reset_readdata", bus.readdata, 32'd0);
    check("midcount_reset_irq", {31'd0, irq}, 32'd0);
    cyc();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a));
    repeat (D + 4) rd(3'd0);
    rd(3'd3);
    check("no_capture_after_reset", bus.readdata, 32'd0);

    // Randomised traffic against the model
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 9))
        0, 1: wr(3'($urandom_range(0, 7)), $urandom);
        2, 3, 4: rd(3'($urandom_range(0, 7)));
        5: begin in_port = in_port ^ W'($urandom); cyc(); end
        6: begin
          in_port = in_port ^ W'($urandom);
          repeat ($urandom_range(D + 1, D + 14)) rd(3'($urandom_range(0, 4)));
        end
        default: cyc();
      endcase
    end
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
